// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle divider: state encodings, default
// width and the Hi/Lo mux select value that the control unit uses for it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  // Hi/Lo write-data select that routes hi_out/lo_out into the register pair.
  localparam logic [1:0] HILO_SEL_DIV = 2'd2;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider for MIPS DIV: quotient to Lo, remainder
// to Hi, one-cycle done pulse, divide-by-zero flag instead of a result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for start; zero divisor answers with done+div_zero
// DIV_RUN  | one restoring step per clock, WIDTH steps on magnitudes
// DIV_FIX  | apply signs, register hi_out/lo_out, pulse done
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_dvs_zero;
  logic             w_cnt_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;

  assign w_dvs_zero = (divisor == '0);
  assign w_cnt_last = (r_cnt == CNT_W'(1));
  // |-2^(W-1)| wraps to itself, which is the correct unsigned magnitude
  assign w_abs_a    = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_abs_b    = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (start && !w_dvs_zero) w_state_nxt = DIV_RUN;
      DIV_RUN:  if (w_cnt_last)           w_state_nxt = DIV_FIX;
      DIV_FIX:                            w_state_nxt = DIV_IDLE;
      default:                            w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start && w_dvs_zero) begin
            r_done <= 1'b1;
            r_dz   <= 1'b1;
          end else if (start) begin
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= '0;
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
            r_cnt   <= CNT_W'(WIDTH);
          end
        end
        DIV_RUN: begin
          // remainder stays below the divisor, so WIDTH bits always suffice
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        DIV_FIX: begin
          r_lo   <= r_neg_q ? -r_quo : r_quo;
          r_hi   <= r_neg_r ? -r_rem : r_rem;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != DIV_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized self-checking bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_err    = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; returns 1ns after the sampling edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (1ns after an edge), bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cyc;
    do_start(a, b);
    wait_done(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd33);
    chk({tag, "_lo"}, lo_out, exp_lo);
    chk({tag, "_hi"}, hi_out, exp_hi);
    chk({tag, "_dz"}, 32'(div_zero), 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [31:0] a, b, q, r;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz",   32'(div_zero), 32'd0);
    chk("rst_hi",   hi_out, 32'd0);
    chk("rst_lo",   lo_out, 32'd0);

    // 7/2 with busy profile
    do_start(32'd7, 32'd2);
    chk("b7_busy0", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("b7_lat", 32'(cyc), 32'd33);
    chk("b7_busy_done", 32'(busy), 32'd0);
    chk("b7_lo", lo_out, 32'h3);
    chk("b7_hi", hi_out, 32'h1);
    chk("b7_dz", 32'(div_zero), 32'd0);
    @(posedge clk);
    #1;
    chk("b7_done_pulse", 32'(done), 32'd0);

    run_case("n7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_case("p7_n2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1);
    run_case("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    run_case("min_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'h0);

    // divide by zero keeps previous hi/lo
    run_case("pre5_2", 32'd5, 32'd2, 32'd2, 32'd1);
    do_start(32'd5, 32'd0);
    chk("dz_done", 32'(done), 32'd1);
    chk("dz_flag", 32'(div_zero), 32'd1);
    chk("dz_busy", 32'(busy), 32'd0);
    chk("dz_hi", hi_out, 32'd1);
    chk("dz_lo", lo_out, 32'd2);
    @(posedge clk);
    #1;
    chk("dz_done_pulse", 32'(done), 32'd0);
    chk("dz_flag_pulse", 32'(div_zero), 32'd0);

    // reset mid-division aborts with no done
    do_start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_hi", hi_out, 32'd0);
    chk("ab_lo", lo_out, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("ab_no_done", 32'(pulses), 32'd0);

    // start while busy is ignored
    do_start(32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    chk("ign_lat", 32'(cyc), 32'd28);
    chk("ign_lo", lo_out, 32'd14);
    chk("ign_hi", hi_out, 32'd2);

    // back-to-back: start in the done cycle
    do_start(32'd100, 32'd7);
    wait_done(cyc);
    chk("bb1_lat", 32'(cyc), 32'd33);
    chk("bb1_lo", lo_out, 32'd14);
    dividend = 32'hFFFF_FF9C;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    chk("bb2_lat", 32'(cyc), 32'd33);
    chk("bb2_lo", lo_out, 32'hFFFF_FFF2);
    chk("bb2_hi", hi_out, 32'hFFFF_FFFE);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (b == 32'd0) b = 32'd1;
      ref_div(a, b, q, r);
      do_start(a, b);
      wait_done(cyc);
      chk("rnd_lat", 32'(cyc), 32'd33);
      chk("rnd_lo", lo_out, q);
      chk("rnd_hi", hi_out, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
